// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT parameters and index helpers
package fft_pkg;

  localparam int FFT_DATA_W    = 32;
  localparam int FFT_LOG2N     = 3;
  localparam int FFT_IDX_MAX_W = 16;

  typedef logic [FFT_IDX_MAX_W-1:0] fft_idx_t;

  // Reverses the low nbits bits of idx; bits above nbits come back as zero.
  function automatic fft_idx_t bitrev(input fft_idx_t idx, input int nbits);
    fft_idx_t src;
    fft_idx_t res;
    src = idx;
    res = '0;
    for (int i = 0; i < FFT_IDX_MAX_W; i++) begin
      if (i < nbits) begin
        res = {res[FFT_IDX_MAX_W-2:0], src[0]};
        src = src >> 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// rtl/fft_reorder_bank.sv - N x DATA_W register array, one write port, one async read port
module fft_reorder_bank
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int LOG2N  = FFT_LOG2N
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [LOG2N-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [LOG2N-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int N = 1 << LOG2N;

  // Contents are deliberately not reset; a bank is only read once its full flag is set.
  logic [DATA_W-1:0] mem_q [N];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - ping-pong reorder of bit-reversed FFT output into natural order
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int LOG2N  = FFT_LOG2N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [LOG2N-1:0]  out_index,
  output logic              out_last,
  input  logic              out_ready
);

  localparam logic [LOG2N-1:0] CNT_MAX = {LOG2N{1'b1}};

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;

  logic             wr_fire;
  logic             rd_fire;
  logic [LOG2N-1:0] wr_addr;
  logic [DATA_W-1:0] rd_data0;
  logic [DATA_W-1:0] rd_data1;

  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign out_data  = rd_bank_q ? rd_data1 : rd_data0;
  assign out_index = rd_cnt_q;
  assign out_last  = out_valid && (rd_cnt_q == CNT_MAX);

  assign wr_fire = in_valid && in_ready;
  assign rd_fire = out_valid && out_ready;

  // Scatter on write so the read side can walk addresses in natural order.
  assign wr_addr = LOG2N'(bitrev(fft_idx_t'(wr_cnt_q), LOG2N));

  fft_reorder_bank #(
    .DATA_W (DATA_W),
    .LOG2N  (LOG2N)
  ) u_bank0 (
    .clk     (clk),
    .wr_en   (wr_fire && !wr_bank_q),
    .wr_addr (wr_addr),
    .wr_data (in_data),
    .rd_addr (rd_cnt_q),
    .rd_data (rd_data0)
  );

  fft_reorder_bank #(
    .DATA_W (DATA_W),
    .LOG2N  (LOG2N)
  ) u_bank1 (
    .clk     (clk),
    .wr_en   (wr_fire && wr_bank_q),
    .wr_addr (wr_addr),
    .wr_data (in_data),
    .rd_addr (rd_cnt_q),
    .rd_data (rd_data1)
  );

  // Writes only target a non-full bank and reads only a full one, so the
  // set and clear below never hit the same flag in one cycle.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;

    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_cnt_q == CNT_MAX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end

    if (rd_fire) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
      if (rd_cnt_q == CNT_MAX) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb/tb_fft_out_reorder.sv - self-checking bench for fft_out_reorder
module tb_fft_out_reorder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  out_index;
  logic        out_last;
  logic        out_ready;

  fft_out_reorder #(.DATA_W(32), .LOG2N(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  logic [31:0] exp_q[$];
  int          exp_i[$];
  logic [31:0] fbuf[$];
  int          nib[$];
  int          tbl[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  bit stream_on;
  bit seen_first;
  int stream_outs;
  int gap_cnt;
  int nready_cnt;
  bit dmy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int rev3(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  // One clock: drive at negedge, check against the model, then advance the model.
  task automatic step(input bit iv, input logic [31:0] id, input bit ordy, output bit acc);
    int  pend;
    bit  rd;
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    pend = (exp_q.size() + 7) / 8;
    chk("in_ready", in_ready, pend < 2);
    chk("out_valid", out_valid, pend > 0);
    if (pend > 0) begin
      chk("out_data", out_data, exp_q[0]);
      chk("out_index", out_index, exp_i[0]);
      chk("out_last", out_last, exp_i[0] == 7);
    end else begin
      chk("out_last_idle", out_last, 0);
    end
    if (stream_on) begin
      if (!in_ready) nready_cnt++;
      if (seen_first && stream_outs < 32 && !out_valid) gap_cnt++;
      if (out_valid) seen_first = 1'b1;
      if (out_valid && ordy) stream_outs++;
    end
    if (out_valid && ordy) nib.push_back(int'(out_data[3:0]));
    rd  = ordy && (pend > 0);
    acc = iv && (pend < 2);
    if (rd) begin
      void'(exp_q.pop_front());
      void'(exp_i.pop_front());
    end
    if (acc) begin
      fbuf.push_back(id);
      if (fbuf.size() == 8) begin
        for (int k = 0; k < 8; k++) begin
          exp_q.push_back(fbuf[rev3(k)]);
          exp_i.push_back(k);
        end
        fbuf.delete();
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_index", out_index, 0);
    exp_q.delete();
    exp_i.delete();
    fbuf.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    bit a;
    for (int i = 0; i < 64 && exp_q.size() > 0; i++) step(1'b0, $urandom, 1'b1, a);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout remaining=%0d required=0", exp_q.size());
    end
  endtask

  task automatic check_nibbles(input string tag);
    chk({tag, "_count"}, nib.size(), 8);
    for (int k = 0; k < 8 && k < nib.size(); k++) chk({tag, "_nibble"}, nib[k], tbl[k]);
  endtask

  initial begin
    logic [31:0] words[24];
    int          wi;
    int          hold;
    bit          acc;

    checks = 0; failures = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    stream_on = 0; seen_first = 0; stream_outs = 0; gap_cnt = 0; nready_cnt = 0;

    do_reset();

    // single frame, back-to-back
    nib.delete();
    for (int j = 0; j < 8; j++) step(1'b1, 32'(j), 1'b1, dmy);
    drain();
    check_nibbles("single");

    // bubbles on the input side
    nib.delete();
    for (int j = 0; j < 8; j++) begin
      step(1'b1, 32'(j), 1'b1, dmy);
      step(1'b0, $urandom, 1'b1, dmy);
    end
    drain();
    check_nibbles("bubble");

    // backpressure: three frames offered while downstream is stalled
    for (int i = 0; i < 24; i++) words[i] = $urandom;
    wi = 0; hold = 0;
    for (int c = 0; c < 80 && wi < 24; c++) begin
      step(1'b1, words[wi], c >= 24, acc);
      if (acc) wi++;
      else if (wi == 16) hold++;
    end
    chk("bp_all_accepted", wi, 24);
    chk("bp_17th_held", hold > 0, 1);
    drain();

    // streaming with both handshakes held high
    stream_on = 1'b1;
    for (int j = 0; j < 32; j++) step(1'b1, $urandom, 1'b1, dmy);
    drain();
    stream_on = 1'b0;
    chk("stream_outputs", stream_outs, 32);
    chk("stream_gaps", gap_cnt, 0);
    chk("stream_in_ready_low", nready_cnt, 0);

    // random stalls on both sides
    for (int i = 0; i < 24; i++) words[i] = $urandom;
    wi = 0;
    for (int c = 0; c < 400 && wi < 24; c++) begin
      step(1'($urandom_range(0, 1)), words[wi], 1'($urandom_range(0, 1)), acc);
      if (acc) wi++;
    end
    chk("stall_all_accepted", wi, 24);
    drain();

    // reset with frame 1 half read and frame 2 partly written
    for (int j = 0; j < 8; j++) step(1'b1, $urandom, 1'b0, dmy);
    for (int j = 0; j < 5; j++) step(1'b1, $urandom, j < 4, dmy);
    do_reset();
    nib.delete();
    for (int j = 0; j < 8; j++) step(1'b1, 32'h3C00_0000 | 32'(j), 1'b1, dmy);
    drain();
    check_nibbles("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_out_reorder.md
FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

Interface
REQ-001 SHALL have parameter DATA_W, default 32: complex word width, with real part in [DATA_W-1:DATA_W/2] and imag part in [DATA_W/2-1:0], both IEEE-754 half.
REQ-002 SHALL have parameter LOG2N, default 3: log2 of frame length N (N=8).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: butterfly output word present.
REQ-006 SHALL have port in_data, input, DATA_W bits: complex result, arriving in bit-reversed index order.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-009 SHALL have port out_data, output, DATA_W bits: complex result in natural index order.
REQ-010 SHALL have port out_index, output, LOG2N bits: natural index of out_data.
REQ-011 SHALL have port out_last, output, 1 bit: high with out_valid on index N-1.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts out_data.

Function
REQ-013 SHALL hold two N-entry banks (ping-pong), each with a full flag; wr_bank, rd_bank, wr_cnt and rd_cnt are registers.
REQ-014 SHALL accept a word when in_valid&&in_ready and write it to address bitrev(wr_cnt) of wr_bank, then increment wr_cnt modulo N.
REQ-015 SHALL, on accepting the word with wr_cnt==N-1, set full[wr_bank] and toggle wr_bank in the same edge.
REQ-016 SHALL drive in_ready = !full[wr_bank] (combinational from registers, no dependency on in_valid).
REQ-017 SHALL drive out_valid = full[rd_bank], out_data = bank[rd_bank][rd_cnt], out_index = rd_cnt, out_last = out_valid&&(rd_cnt==N-1).
REQ-018 SHALL advance rd_cnt on out_valid&&out_ready; when rd_cnt==N-1 it SHALL clear full[rd_bank], toggle rd_bank and wrap rd_cnt to 0.
REQ-019 SHALL assert out_valid on the first rising edge after the Nth word of a frame is accepted (latency 1 cycle); the first output is index 0.
REQ-020 SHALL keep out_data/out_index stable while out_valid&&!out_ready.
REQ-021 SHALL handle a simultaneous last-write into one bank and last-read from the other in the same cycle, setting and clearing the two flags independently.
REQ-022 SHALL sustain 1 word/cycle in and out with both handshakes held high, with no bubbles after the first frame.
REQ-023 SHALL deassert in_ready when both banks are full; no write occurs and wr_cnt holds.
REQ-024 SHALL ignore in_data when in_valid=0; out_ready while out_valid=0 has no effect.

Reset
REQ-025 SHALL, on rst high, immediately clear full[1:0], wr_bank, rd_bank, wr_cnt and rd_cnt, so that out_valid=0, out_last=0, out_index=0 and in_ready=1.
REQ-026 SHALL discard partial frames on reset mid-frame; bank storage SHALL NOT be reset, and out_data is don't-care while out_valid=0.

Structure
REQ-027 SHALL take DATA_W/LOG2N defaults and a bitrev(LOG2N) function from shared package fft_pkg, which is also used by the twiddle/butterfly blocks.
REQ-028 SHALL instantiate one sub-module, fft_reorder_bank: an N x DATA_W register array with one write port and one asynchronous read port, used twice.

Verification
REQ-029 SHALL verify single frame: rst, then in_data=32'h0000_000j for j=0..7 back-to-back, out_ready=1 -> out_data low nibble sequence 0,4,2,6,1,5,3,7; out_index 0..7; out_last only on the 8th; out_valid rises 1 cycle after the 8th input.
REQ-030 SHALL verify backpressure: 3 frames in with out_ready=0 -> in_ready=0 after 16 accepted words; 17th word held; release out_ready -> frame 1, then frame 2, then frame 3 emitted intact.
REQ-031 SHALL verify streaming: 4 frames, in_valid=out_ready=1 continuously -> 32 outputs with no out_valid gap after the first, and in_ready constantly 1.
REQ-032 SHALL verify stall stability: out_ready toggled pseudo-randomly -> out_data/out_index unchanged during stalls, with no loss or duplication.
REQ-033 SHALL verify reset mid-operation: rst asserted after 5 words of frame 2 while frame 1 is half-read -> out_valid=0 and in_ready=1 immediately; a new frame 32'h3C00_000j (j=0..7) then reorders correctly.
REQ-034 SHALL verify bubbles: in_valid low on alternate cycles -> same reordered output as REQ-029.
